// File: rtl/line_window_pkg.sv
// Shared widths and window byte layout for the 3x3 line window generator.
// Used by line_window_gen and line_window_lbuf.
package line_window_pkg;

    localparam int PIXEL_W     = 8;
    localparam int KERNEL_DIM  = 3;
    localparam int KERNEL_TAPS = KERNEL_DIM * KERNEL_DIM;
    localparam int WINDOW_W    = KERNEL_TAPS * PIXEL_W;

    // Byte index of window tap (r,c); row 0 is the top line, col 0 the left column.
    function automatic int win_byte_off(input int r, input int c);
        return r * KERNEL_DIM + c;
    endfunction

endpackage

// File: rtl/line_window_lbuf.sv
// One image line of pixel storage: combinational read, synchronous write.
// A same-cycle read returns the value held before the write.
module line_window_lbuf
    import line_window_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_addr,
    input  logic [PIXEL_W-1:0] i_wdata,
    output logic [PIXEL_W-1:0] o_rdata
);

    logic [PIXEL_W-1:0] mem_r [DEPTH];

    assign o_rdata = mem_r[i_addr];

    // Line storage write port; contents need no reset because they are never emitted before rewrite.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/line_window_gen.sv
// Streaming 3x3 window generator feeding the convolution stage.
// Optional macro WINGEN_SOF_EN adds i_sof (frame restart) and o_eof (last window flag).
module line_window_gen
    import line_window_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PIXEL_W-1:0]  i_pixel_data,
    input  logic                i_pixel_data_valid,
    output logic [WINDOW_W-1:0] o_pixel_data,
    output logic                o_pixel_data_valid
`ifdef WINGEN_SOF_EN
    ,
    input  logic                i_sof,
    output logic                o_eof
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_DIM - 1);
    localparam logic [RW-1:0] ROW_ZERO  = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_DIM - 1);

    logic [CW-1:0]       col_r, col_eff_s, col_nxt_s;
    logic [RW-1:0]       row_r, row_eff_s, row_nxt_s;
    logic                win_hit_s;
    logic                pend_r;
    logic [PIXEL_W-1:0]  lb_a_rd_s, lb_b_rd_s;
    logic [PIXEL_W-1:0]  top_r [KERNEL_DIM];
    logic [PIXEL_W-1:0]  mid_r [KERNEL_DIM];
    logic [PIXEL_W-1:0]  bot_r [KERNEL_DIM];
    logic [WINDOW_W-1:0] window_s;

    // Effective pixel position (SOF override) and the position of the following pixel.
    always_comb begin
        col_eff_s = col_r;
        row_eff_s = row_r;
        col_nxt_s = COL_ZERO;
        row_nxt_s = ROW_ZERO;
`ifdef WINGEN_SOF_EN
        if (i_sof) begin
            col_eff_s = COL_ZERO;
            row_eff_s = ROW_ZERO;
        end else begin
            col_eff_s = col_r;
            row_eff_s = row_r;
        end
`endif
        if (col_eff_s == COL_LAST) begin
            col_nxt_s = COL_ZERO;
            if (row_eff_s == ROW_LAST) begin
                row_nxt_s = ROW_ZERO;
            end else begin
                row_nxt_s = row_eff_s + ROW_ONE;
            end
        end else begin
            col_nxt_s = col_eff_s + COL_ONE;
            row_nxt_s = row_eff_s;
        end
        win_hit_s = (row_eff_s >= ROW_FIRST) && (col_eff_s >= COL_FIRST);
    end

    // Raster position counters, advanced only by accepted pixels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (i_pixel_data_valid) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // lb_a holds the previous line; lb_b receives what lb_a held, i.e. the line before that.
    line_window_lbuf #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_a (
        .i_clk   (i_clk),
        .i_we    (i_pixel_data_valid),
        .i_addr  (col_eff_s),
        .i_wdata (i_pixel_data),
        .o_rdata (lb_a_rd_s)
    );

    line_window_lbuf #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_b (
        .i_clk   (i_clk),
        .i_we    (i_pixel_data_valid),
        .i_addr  (col_eff_s),
        .i_wdata (lb_a_rd_s),
        .o_rdata (lb_b_rd_s)
    );

    // Column shift registers; index KERNEL_DIM-1 receives the newest column.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < KERNEL_DIM; c++) begin
                top_r[c] <= {PIXEL_W{1'b0}};
                mid_r[c] <= {PIXEL_W{1'b0}};
                bot_r[c] <= {PIXEL_W{1'b0}};
            end
        end else if (i_pixel_data_valid) begin
            for (int c = 0; c < KERNEL_DIM - 1; c++) begin
                top_r[c] <= top_r[c+1];
                mid_r[c] <= mid_r[c+1];
                bot_r[c] <= bot_r[c+1];
            end
            top_r[KERNEL_DIM-1] <= lb_b_rd_s;
            mid_r[KERNEL_DIM-1] <= lb_a_rd_s;
            bot_r[KERNEL_DIM-1] <= i_pixel_data;
        end else begin
            top_r <= top_r;
            mid_r <= mid_r;
            bot_r <= bot_r;
        end
    end

    // Flatten the shift registers into the output byte layout.
    always_comb begin
        window_s = {WINDOW_W{1'b0}};
        for (int c = 0; c < KERNEL_DIM; c++) begin
            window_s[win_byte_off(0, c)*PIXEL_W +: PIXEL_W] = top_r[c];
            window_s[win_byte_off(1, c)*PIXEL_W +: PIXEL_W] = mid_r[c];
            window_s[win_byte_off(2, c)*PIXEL_W +: PIXEL_W] = bot_r[c];
        end
    end

    // Marks that the pixel just shifted in completed a window fully inside the image.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= i_pixel_data_valid & win_hit_s;
        end
    end

    // Output register; data holds between windows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pixel_data       <= {WINDOW_W{1'b0}};
            o_pixel_data_valid <= 1'b0;
        end else begin
            o_pixel_data_valid <= pend_r;
            if (pend_r) begin
                o_pixel_data <= window_s;
            end else begin
                o_pixel_data <= o_pixel_data;
            end
        end
    end

`ifdef WINGEN_SOF_EN
    logic eof_pend_r;

    // Last-window flag, staged to line up with o_pixel_data_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            eof_pend_r <= 1'b0;
            o_eof      <= 1'b0;
        end else begin
            eof_pend_r <= i_pixel_data_valid & (row_eff_s == ROW_LAST) & (col_eff_s == COL_LAST);
            o_eof      <= eof_pend_r;
        end
    end
`endif

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Streaming 3x3 window generator that produces the 72-bit pixel bus consumed by the convolution stage.
- Accepts one 8-bit raster-order pixel per valid cycle.
- Buffers the two previous image lines and emits one complete 3x3 neighbourhood per accepted pixel once the window is fully inside the image.
- Sits between the pixel source (DMA/stream input) and the conv filter.

Parameters:
- IMG_WIDTH, 512, pixels per line; must be >= 3.
- IMG_HEIGHT, 512, lines per frame; must be >= 3.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_pixel_data  input  8  unsigned pixel, raster order.
- i_pixel_data_valid  input  1  qualifies i_pixel_data; no backpressure, so every valid cycle is consumed.
- o_pixel_data  output  72  3x3 window; byte k = bits [k*8+:8], row r=k/3, col c=k%3. r=0 is the oldest (top) line, c=0 the oldest (left) column, so byte 8 is the newest pixel.
- o_pixel_data_valid  output  1  qualifies o_pixel_data; high for exactly one cycle per emitted window.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_pixel_data=0, o_pixel_data_valid=0.
  - Column and row counters = 0; window shift registers = 0.
  - Line-buffer contents are don't-care: never emitted before being rewritten.
- Counters:
  - col 0..IMG_WIDTH-1; row 0..IMG_HEIGHT-1.
  - Both advance only on cycles where i_pixel_data_valid=1.
  - col wraps to 0 at IMG_WIDTH-1 and increments row.
  - row wraps to 0 after the last pixel of the frame, so the next frame starts with no gap.
- Line buffers:
  - lb_a holds line row-1, lb_b holds line row-2, each IMG_WIDTH x 8.
  - On an accepted pixel at col:
    - read lb_a[col] and lb_b[col] (read-before-write);
    - write lb_b[col] <= old lb_a[col];
    - write lb_a[col] <= i_pixel_data.
- Window:
  - Three 3-deep column shift registers (top, mid, bot) shift on each accepted pixel, loading lb_b[col], lb_a[col], i_pixel_data.
  - Registers are not cleared at line wrap; the valid gating below hides the stale columns.
- Output:
  - Registered, latency 1 cycle: the window containing the pixel accepted at edge N appears after edge N+1.
  - o_pixel_data_valid=1 iff the accepted pixel had row>=2 and col>=2.
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Idle and back-to-back:
  - When i_pixel_data_valid=0, all state holds and o_pixel_data_valid drops to 0 on the next cycle; o_pixel_data holds its last value.
  - Gaps between pixels are allowed anywhere.
  - Back-to-back valid input yields back-to-back valid output.
- Reset mid-frame: counters restart at (0,0); the next frame must not emit a window until row>=2 again.
- No arithmetic beyond counters; counter widths are $clog2 of the respective parameter.

Optional Feature:
- Macro: WINGEN_SOF_EN.
- Defined:
  - Adds input i_sof (1 bit) and output o_eof (1 bit, reset 0).
  - An accepted pixel with i_sof=1 is treated as (row 0, col 0) regardless of the counter state; counters continue from there.
  - o_eof pulses together with o_pixel_data_valid for the final window of the frame (pixel row=IMG_HEIGHT-1, col=IMG_WIDTH-1).
  - i_sof=1 with i_pixel_data_valid=0 is ignored.
- Undefined: ports absent; framing is purely counter-based.

Decomposition:
- Package line_window_pkg:
  - PIXEL_W=8, KERNEL_DIM=3, KERNEL_TAPS=9, WINDOW_W=72;
  - a function mapping (r,c) to a byte offset.
- Sub-module line_window_lbuf:
  - single-port IMG_WIDTH x 8 read-before-write memory with write enable and registered-free (combinational) read;
  - instantiated twice (lb_a, lb_b).
- Counters, shift registers and output stage stay in the top module.

Test Plan:
- Reset, then stream a 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4, pixel=row*16+col, continuous valid):
  - exactly 4 windows;
  - first window = 72'h22_21_20_12_11_10_02_01_00, valid 1 cycle after pixel 0x22 is accepted;
  - last window = 72'h33_32_31_23_22_21_13_12_11.
- Same frame with valid toggled every other cycle: identical 4 windows, each valid pulse one cycle after the corresponding accepted pixel, no extra pulses.
- Two back-to-back 4x4 frames (second uses pixel+0x80): the second frame's first window = 72'hA2_A1_A0_92_91_90_82_81_80; no window during rows 0-1 of frame 2.
- Assert i_rst after pixel 0x21, then stream a fresh frame: no output until the new (2,2) pixel; o_pixel_data=0 and valid=0 during reset.
- With WINGEN_SOF_EN, IMG 4x4: send 5 junk pixels, then a frame with i_sof on pixel 0x00:
  - windows match the first scenario;
  - o_eof=1 only with window 72'h33_..._11.
